range_sequencer: RTL and testbench
==================================

Name: range_sequencer

Overview:
- Transmitter side of the go/finish/data range-measurement protocol.
- Buffers up to DEPTH samples from a write port, then plays them out as one measurement: go on the first sample, finish on the last.
- Computes the expected max-min locally, samples the measurement block's range and error outputs, and reports pass or fail.
- Sits next to the range-measurement block inside the top-level chip wrapper as a built-in self-test source.

Parameters:
- WIDTH, 8, bits per sample and per range value.
- DEPTH, 16, sample buffer entries; must be a power of 2 and at least 2.
- RESULT_LAT, 1, cycles from the finish cycle to the cycle range_in/error_in are sampled; must be at least 1.

Ports:
- clock  input  1  single clock, all state on the rising edge.
- reset_n  input  1  asynchronous, active-low reset.
- wr_en  input  1  push wr_data into the buffer.
- wr_data  input  WIDTH  sample to store.
- clear  input  1  empty the buffer; honoured only in IDLE.
- start  input  1  begin playback; honoured only in IDLE.
- busy  output  1  high while not in IDLE.
- full  output  1  count == DEPTH.
- start_err  output  1  one-cycle pulse when start is rejected because count < 2.
- ovf_err  output  1  one-cycle pulse when wr_en is dropped because the buffer is full.
- go  output  1  protocol start strobe.
- finish  output  1  protocol end strobe.
- data_out  output  WIDTH  protocol sample.
- range_in  input  WIDTH  range returned by the measurement block.
- error_in  input  1  error flag returned by the measurement block.
- expected  output  WIDTH  locally computed max-min from the last run.
- done  output  1  one-cycle pulse when the result is valid.
- pass  output  1  sticky; cleared by start, clear or reset.
- fail  output  1  sticky; cleared by start, clear or reset.

Behaviour:
- Reset (asynchronous, takes effect immediately):
  - state=IDLE, count=0, read index=0.
  - All outputs 0, including go, finish and data_out; buffer contents are don't-care.
- Buffer write:
  - In IDLE, wr_en with count<DEPTH stores wr_data at mem[count] and increments count.
  - wr_en while full is dropped and pulses ovf_err in the next cycle.
  - wr_en while busy is silently ignored.
  - clear in IDLE sets count=0 and clears pass/fail. clear and wr_en together: clear wins.
- Buffer retention: contents survive playback, so start can replay the same buffer.
- States: IDLE -> PLAY -> WAIT -> CHECK -> IDLE.
- IDLE:
  - start with count>=2: clear pass/fail, set index=0, go to PLAY.
  - start with count<2: stay in IDLE and pulse start_err the next cycle.
  - start and wr_en together: the write happens; start evaluates the pre-write count.
- PLAY (go, finish and data_out are registered):
  - start sampled high in cycle t gives go=1 and data_out=mem[0] in cycle t+1.
  - Each following cycle presents the next sample.
  - finish=1 with data_out=mem[count-1] in cycle t+count.
  - go and finish are never high in the same cycle; outside PLAY both are 0 and data_out holds 0.
  - Running min/max update on every presented sample; expected=max-min as unsigned WIDTH bits, no wrap possible.
- WAIT:
  - Counts RESULT_LAT cycles after the finish cycle.
  - range_in and error_in are sampled in cycle t+count+RESULT_LAT.
- CHECK:
  - fail=1 if error_in=1 or range_in!=expected; otherwise pass=1.
  - done pulses in cycle t+count+RESULT_LAT+1, and the block returns to IDLE in the same cycle.
- Exclusivity: pass and fail are never both 1.
- Mid-run inputs: start, clear and wr_en are ignored in PLAY, WAIT and CHECK.
- Reset mid-run: go and finish drop asynchronously and the run is abandoned; no done pulse.

Decomposition:
- Shared package range_pkg:
  - seq_state_t enum {IDLE, PLAY, WAIT, CHECK}.
  - Default WIDTH, DEPTH and RESULT_LAT localparams shared with the measurement block.
- One sub-module, range_sample_buf:
  - DEPTH x WIDTH register file with write pointer/count and a synchronous indexed read.
  - Provides full and count.
  - The sequencer FSM, min/max tracking and checker stay in range_sequencer.

Test Plan:
- Basic pass: write 5,3,9,7; start at t.
  - go=1 and data_out=5 at t+1; samples 3,9 follow; finish=1 and data_out=7 at t+4.
  - expected=6; drive range_in=6 at t+5 -> done and pass=1 at t+6.
- Mismatch: same buffer, drive range_in=5 -> fail=1, pass=0. Then error_in=1 with range_in=6 -> fail=1.
- Replay and clear:
  - Second start without rewriting replays 5,3,9,7; pass/fail clear at start.
  - clear then start -> start_err pulse, go stays 0.
- Rejected start: write one sample (42), start -> start_err=1 for one cycle, busy=0, go/finish stay 0.
- Overflow: 17 writes with DEPTH=16 -> full=1 after the 16th; 17th dropped with ovf_err pulse. Playback shows exactly 16 samples with finish on the 16th.
- Reset and busy ignores:
  - Assert reset_n=0 during PLAY at index 2 -> go, finish, busy, data_out go to 0 immediately; count=0 after release; no done pulse.
  - wr_en during PLAY does not change count.

Source files
------------

// File: rtl/range_pkg.sv
// range_pkg: shared state type and default sizing for the range sequencer and measurement block
package range_pkg;
  localparam int DEF_WIDTH      = 8;
  localparam int DEF_DEPTH      = 16;
  localparam int DEF_RESULT_LAT = 1;
  typedef enum logic [1:0] {IDLE, PLAY, WAIT, CHECK} seq_state_t;
endpackage

// File: rtl/range_if.sv
// range_if: go/finish/data range-measurement protocol bundle
// master (sequencer): drives go, finish, data_out; receives range_in, error_in
// slave (measurement block): the mirror image
interface range_if import range_pkg::*; #(parameter int WIDTH = DEF_WIDTH);
  logic             go;
  logic             finish;
  logic [WIDTH-1:0] data_out;
  logic [WIDTH-1:0] range_in;
  logic             error_in;
  modport master(output go, finish, data_out, input range_in, error_in);
  modport slave(input go, finish, data_out, output range_in, error_in);
endinterface

// File: rtl/range_sample_buf.sv
// range_sample_buf: DEPTH x WIDTH sample store with fill count and registered indexed read
// ports: clock, reset_n (async active-low); wr_en/wr_data append at mem[count]; clear empties;
//        rd_en/rd_idx load rd_data next cycle (0 when rd_en low); count and full report fill level
module range_sample_buf import range_pkg::*; #(
  parameter int WIDTH = DEF_WIDTH,
  parameter int DEPTH = DEF_DEPTH,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             wr_en,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             clear,
  input  logic             rd_en,
  input  logic [AW-1:0]    rd_idx,
  output logic [WIDTH-1:0] rd_data,
  output logic [AW:0]      count,
  output logic             full
);
  logic [WIDTH-1:0] mem [DEPTH];
  logic wr_ok;
  assign full  = count == (AW+1)'(DEPTH);
  assign wr_ok = wr_en && !clear && !full;
  always_ff @(posedge clock)
    if (wr_ok) mem[count[AW-1:0]] <= wr_data;
  always_ff @(posedge clock or negedge reset_n)
    if (!reset_n) begin
      count   <= '0;
      rd_data <= '0;
    end else begin
      count   <= clear ? '0 : count + (AW+1)'(wr_ok);
      rd_data <= rd_en ? mem[rd_idx] : '0;
    end
endmodule

// File: rtl/range_sequencer.sv
// range_sequencer: buffers samples, plays them out as one go/finish measurement and checks the returned range
// ports: clock, reset_n (async active-low); wr_en/wr_data/clear/start control the buffer and playback;
//        busy/full/start_err/ovf_err report status; expected/done/pass/fail report the check;
//        bus (range_if.master) carries go/finish/data_out out and range_in/error_in back
module range_sequencer import range_pkg::*; #(
  parameter int WIDTH      = DEF_WIDTH,
  parameter int DEPTH      = DEF_DEPTH,
  parameter int RESULT_LAT = DEF_RESULT_LAT
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             wr_en,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             clear,
  input  logic             start,
  output logic             busy,
  output logic             full,
  output logic             start_err,
  output logic             ovf_err,
  output logic [WIDTH-1:0] expected,
  output logic             done,
  output logic             pass,
  output logic             fail,
  range_if.master          bus
);
  localparam int AW = $clog2(DEPTH);
  localparam int LW = $clog2(RESULT_LAT + 1);
  seq_state_t state, state_nx;
  logic [AW:0] count;
  logic [AW-1:0] idx, idx_nx, rd_idx;
  logic [LW-1:0] wcnt, wcnt_nx;
  logic [WIDTH-1:0] data, mn, mx, mn_cur, mx_cur;
  logic idle, start_ok, last, rd_en, go_q, go_nx, finish_q, finish_nx, to_check, mis;
  assign idle     = state == IDLE;
  assign busy     = !idle;
  assign start_ok = idle && start && !clear && count >= (AW+1)'(2);
  assign last     = (AW+1)'(idx) == count - (AW+1)'(1);
  assign to_check = state == WAIT && state_nx == CHECK;
  assign mis      = bus.error_in || bus.range_in != expected;
  assign bus.go       = go_q;
  assign bus.finish   = finish_q;
  assign bus.data_out = data;
  // the first presented sample seeds the running extremes
  assign mn_cur = (go_q || data < mn) ? data : mn;
  assign mx_cur = (go_q || data > mx) ? data : mx;
  range_sample_buf #(.WIDTH(WIDTH), .DEPTH(DEPTH)) u_buf (
    .clock   (clock),
    .reset_n (reset_n),
    .wr_en   (idle && wr_en),
    .wr_data (wr_data),
    .clear   (idle && clear),
    .rd_en   (rd_en),
    .rd_idx  (rd_idx),
    .rd_data (data),
    .count   (count),
    .full    (full)
  );
  // idx is the index of the sample presented this cycle; the read issued now lands next cycle
  always_comb begin
    state_nx  = state;
    idx_nx    = idx;
    wcnt_nx   = wcnt;
    rd_en     = 1'b0;
    rd_idx    = idx;
    go_nx     = 1'b0;
    finish_nx = 1'b0;
    case (state)
      IDLE:
        if (start_ok) begin
          state_nx = PLAY;
          idx_nx   = '0;
          rd_en    = 1'b1;
          rd_idx   = '0;
          go_nx    = 1'b1;
        end
      PLAY:
        if (last) begin
          state_nx = WAIT;
          wcnt_nx  = '0;
        end else begin
          idx_nx    = idx + 1'b1;
          rd_en     = 1'b1;
          rd_idx    = idx + 1'b1;
          finish_nx = (AW+1)'(idx) + (AW+1)'(1) == count - (AW+1)'(1);
        end
      WAIT:
        if (wcnt == LW'(RESULT_LAT - 1)) state_nx = CHECK;
        else wcnt_nx = wcnt + 1'b1;
      CHECK: state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end
  always_ff @(posedge clock or negedge reset_n)
    if (!reset_n) begin
      state     <= IDLE;
      idx       <= '0;
      wcnt      <= '0;
      go_q      <= 1'b0;
      finish_q  <= 1'b0;
      start_err <= 1'b0;
      ovf_err   <= 1'b0;
      done      <= 1'b0;
      pass      <= 1'b0;
      fail      <= 1'b0;
      mn        <= '0;
      mx        <= '0;
      expected  <= '0;
    end else begin
      state     <= state_nx;
      idx       <= idx_nx;
      wcnt      <= wcnt_nx;
      go_q      <= go_nx;
      finish_q  <= finish_nx;
      start_err <= idle && start && count < (AW+1)'(2);
      ovf_err   <= idle && wr_en && !clear && full;
      done      <= to_check;
      if (state == PLAY) begin
        mn <= mn_cur;
        mx <= mx_cur;
      end
      if (finish_q) expected <= mx_cur - mn_cur;
      if (idle && (start || clear)) begin
        pass <= 1'b0;
        fail <= 1'b0;
      end else if (to_check) begin
        fail <= mis;
        pass <= !mis;
      end
    end
endmodule

// File: tb/tb_range_sequencer.sv
// tb_range_sequencer: directed stimulus with a cycle-level behavioural model and literal spot checks
module tb_range_sequencer;
  localparam int DEPTH = 16;
  localparam int LAT   = 1;
  logic clock = 1'b0;
  logic reset_n = 1'b1;
  logic wr_en = 1'b0, clear = 1'b0, start = 1'b0;
  logic [7:0] wr_data = '0;
  logic busy, full, start_err, ovf_err, done, pass, fail;
  logic [7:0] expected;
  int total = 0, bad = 0;
  range_if #(.WIDTH(8)) bus();
  range_sequencer #(.WIDTH(8), .DEPTH(DEPTH), .RESULT_LAT(LAT)) dut (
    .clock(clock), .reset_n(reset_n), .wr_en(wr_en), .wr_data(wr_data), .clear(clear),
    .start(start), .busy(busy), .full(full), .start_err(start_err), .ovf_err(ovf_err),
    .expected(expected), .done(done), .pass(pass), .fail(fail), .bus(bus)
  );
  always #5 clock = ~clock;
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
    total++;
    if (act !== want) begin
      bad++;
      $display("FAIL %s got=%0h want=%0h at %0t", name, act, want, $time);
    end
  endtask
  // model: buffer as an array, a run as (start cycle, sample snapshot); outputs follow from cycle offsets
  int cyc = 0, t0 = 0, n = 0, mcount = 0, pre = 0, k = 0;
  logic [7:0] mem [DEPTH];
  logic [7:0] snap [DEPTH];
  logic [7:0] m_exp = '0, run_exp = '0, lo, hi;
  bit m_run = 0, m_pass = 0, m_fail = 0, m_serr = 0, m_ovf = 0;
  initial forever begin
    @(posedge clock or negedge reset_n);
    if (!reset_n) begin
      mcount = 0; m_run = 0; m_pass = 0; m_fail = 0; m_serr = 0; m_ovf = 0; m_exp = '0;
    end else begin
      k = cyc - t0;
      m_serr = 0;
      m_ovf = 0;
      if (m_run) begin
        if (k == n) m_exp = run_exp;
        if (k == n + LAT) begin
          m_fail = bus.error_in || bus.range_in != run_exp;
          m_pass = !m_fail;
        end
        if (k == n + LAT + 1) m_run = 0;
      end else begin
        pre = mcount;
        if (start) begin m_pass = 0; m_fail = 0; m_serr = pre < 2; end
        if (clear) begin mcount = 0; m_pass = 0; m_fail = 0; end
        else if (wr_en) begin
          if (mcount == DEPTH) m_ovf = 1;
          else begin mem[mcount] = wr_data; mcount++; end
        end
        if (start && !clear && pre >= 2) begin
          m_run = 1; t0 = cyc; n = mcount;
          lo = 8'hff; hi = 8'h00;
          for (int i = 0; i < n; i++) begin
            snap[i] = mem[i];
            if (mem[i] < lo) lo = mem[i];
            if (mem[i] > hi) hi = mem[i];
          end
          run_exp = hi - lo;
        end
      end
      cyc++;
    end
  end
  initial begin
    int kk;
    logic [7:0] dexp;
    forever begin
      @(negedge clock);
      if (reset_n) begin
        kk = cyc - t0;
        dexp = (m_run && kk >= 1 && kk <= n) ? snap[kk-1] : 8'h00;
        chk("go", bus.go, m_run && kk == 1);
        chk("finish", bus.finish, m_run && kk == n);
        chk("data_out", bus.data_out, dexp);
        chk("busy", busy, m_run);
        chk("done", done, m_run && kk == n + LAT + 1);
        chk("pass", pass, m_pass);
        chk("fail", fail, m_fail);
        chk("full", full, mcount == DEPTH);
        chk("start_err", start_err, m_serr);
        chk("ovf_err", ovf_err, m_ovf);
        chk("expected", expected, m_exp);
      end
    end
  end
  task automatic write(input logic [7:0] v);
    wr_en = 1'b1; wr_data = v;
    @(negedge clock);
    wr_en = 1'b0;
  endtask
  task automatic pulse_start();
    start = 1'b1;
    @(negedge clock);
    start = 1'b0;
  endtask
  task automatic pulse_clear();
    clear = 1'b1;
    @(negedge clock);
    clear = 1'b0;
  endtask
  task automatic wait_done();
    int i;
    i = 0;
    while (!done && i < 40) begin @(negedge clock); i++; end
    chk("done_seen", done, 1);
  endtask
  task automatic run(input logic [7:0] rng, input logic err);
    bus.range_in = rng; bus.error_in = err;
    pulse_start();
    wait_done();
  endtask
  initial begin
    bus.range_in = '0;
    bus.error_in = 1'b0;
    #1 reset_n = 1'b0;
    #1;
    chk("rst_go", bus.go, 0);
    chk("rst_finish", bus.finish, 0);
    chk("rst_data", bus.data_out, 0);
    chk("rst_busy", busy, 0);
    chk("rst_pass_fail", {pass, fail, done}, 0);
    @(negedge clock);
    @(negedge clock);
    reset_n = 1'b1;
    @(negedge clock);
    // basic pass
    write(8'd5); write(8'd3); write(8'd9); write(8'd7);
    bus.range_in = 8'd6; bus.error_in = 1'b0;
    pulse_start();
    chk("b_go", bus.go, 1);
    chk("b_d0", bus.data_out, 5);
    @(negedge clock); chk("b_d1", bus.data_out, 3);
    @(negedge clock); chk("b_d2", bus.data_out, 9);
    @(negedge clock); chk("b_fin", {bus.finish, bus.data_out}, {1'b1, 8'd7});
    @(negedge clock); chk("b_exp", expected, 6);
    @(negedge clock); chk("b_done_pass", {done, pass, fail}, 3'b110);
    @(negedge clock);
    // mismatch, then error flag
    run(8'd5, 1'b0);
    chk("m_fail", {pass, fail}, 2'b01);
    @(negedge clock);
    run(8'd6, 1'b1);
    chk("e_fail", {pass, fail}, 2'b01);
    @(negedge clock);
    // replay clears fail at start; writes during play are ignored
    bus.range_in = 8'd6; bus.error_in = 1'b0;
    pulse_start();
    chk("r_cleared", {pass, fail}, 2'b00);
    chk("r_d0", bus.data_out, 5);
    wr_en = 1'b1; wr_data = 8'd99;
    @(negedge clock);
    wr_en = 1'b0;
    wait_done();
    chk("r_pass", pass, 1);
    @(negedge clock);
    run(8'd6, 1'b0);
    chk("r2_pass", pass, 1);
    @(negedge clock);
    // clear then start is rejected
    pulse_clear();
    chk("c_cleared", pass, 0);
    pulse_start();
    chk("c_serr", {start_err, bus.go}, 2'b10);
    @(negedge clock); chk("c_serr_once", start_err, 0);
    // single sample rejected
    write(8'd42);
    pulse_start();
    chk("s_serr", {start_err, busy, bus.go, bus.finish}, 4'b1000);
    @(negedge clock);
    // overflow: 16 fit, 17th dropped
    pulse_clear();
    for (int i = 0; i < 16; i++) write(8'(10 + i));
    chk("o_full", full, 1);
    write(8'd26);
    chk("o_ovf", ovf_err, 1);
    @(negedge clock); chk("o_ovf_once", ovf_err, 0);
    run(8'd15, 1'b0);
    chk("o_pass", pass, 1);
    @(negedge clock);
    // reset in the middle of playback
    pulse_clear();
    write(8'd1); write(8'd2); write(8'd3); write(8'd4);
    pulse_start();
    @(negedge clock);
    @(negedge clock);
    #2 reset_n = 1'b0;
    #1;
    chk("x_go", bus.go, 0);
    chk("x_finish", bus.finish, 0);
    chk("x_busy", busy, 0);
    chk("x_data", bus.data_out, 0);
    @(negedge clock);
    reset_n = 1'b1;
    @(negedge clock);
    pulse_start();
    chk("x_empty", {start_err, busy}, 2'b10);
    repeat (4) @(negedge clock);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
  initial begin
    #1000000;
    $display("FAIL timeout reached");
    $fatal(1);
  end
endmodule
